// File: rtl/kf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kf_pkg
// Description : Shared types and fixed-point constants for the Kalman filter
//               state-update blocks.
//               - kf_state_t : sequencing states of the state estimate updater
//               - ONE        : 1.0 in the default Q(FRAC) format
//               - acc_width  : MAC accumulator width for a given element width
// Revision    : 1.0 - initial release
// ============================================================================
package kf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRED   = 3'd1,
        ST_WAIT_K = 3'd2,
        ST_INNOV  = 3'd3,
        ST_UPD    = 3'd4,
        ST_DONE   = 3'd5
    } kf_state_t;

    localparam int FRAC_DEFAULT = 8;
    localparam int ONE          = 1 << FRAC_DEFAULT;

    // Four guard bits let up to 16 full-scale products accumulate without
    // overflowing the accumulator.
    localparam int ACC_GUARD = 4;

    function automatic int acc_width(input int width);
        return 2 * width + ACC_GUARD;
    endfunction

endpackage : kf_pkg
`default_nettype wire

// File: rtl/kf_mac.sv
`default_nettype none
// ============================================================================
// Module      : kf_mac
// Description : Signed multiply-accumulate with per-row clear and a
//               shift-and-truncate result tap.
// Ports       : clk      - clock
//               reset    - synchronous active-low reset (clears accumulator)
//               i_en     - accumulate this cycle
//               i_clear  - start of a row: ignore the stored accumulator
//               i_a/i_b  - signed WIDTH operands
//               o_result - ((acc or 0) + a*b) >>> FRAC, truncated to WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module kf_mac #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 2 * WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_clear,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_result
);

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_base;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACC_W - 2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_base     = i_clear ? '0 : r_acc;
    assign w_sum      = w_base + w_prod_ext;

    // Taking WIDTH bits starting at FRAC is an arithmetic right shift by
    // FRAC followed by a wrapping truncation.
    assign o_result = w_sum[FRAC +: WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule : kf_mac
`default_nettype wire

// File: rtl/state_estimate_updater.sv
`default_nettype none
// ============================================================================
// Module      : state_estimate_updater
// Description : One Kalman filter state step on a single time-multiplexed MAC:
//                 x_pred = Fdnk * x_hat
//                 innov  = y - H * x_pred
//                 x_hat  = x_pred + K * innov
//               The gain K is captured on k_valid (generator end_K_G) and is
//               frozen once the innovation pass starts.
// Ports       : clk, reset (sync, active-low; loads x_hat from X0)
//               start_predict - one-cycle step request (IDLE only)
//               Fdnk, H       - model matrices, stable for the whole step
//               y             - measurement, latched with start_predict
//               X0            - initial state
//               K, k_valid    - gain matrix and its strobe
//               x_hat, x_pred, innov - result registers
//               busy          - high outside IDLE
//               done          - one-cycle pulse when x_hat is updated
//               restart_cov   - copy of done, re-arms the covariance stage
// Revision    : 1.0 - initial release
// ============================================================================
module state_estimate_updater
    import kf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int nos   = 4,
    parameter int noo   = 2,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_predict,
    input  logic signed [WIDTH-1:0] Fdnk   [nos][nos],
    input  logic signed [WIDTH-1:0] H      [noo][nos],
    input  logic signed [WIDTH-1:0] y      [noo],
    input  logic signed [WIDTH-1:0] X0     [nos],
    input  logic signed [WIDTH-1:0] K      [nos][noo],
    input  logic                    k_valid,
    output logic signed [WIDTH-1:0] x_hat  [nos],
    output logic signed [WIDTH-1:0] x_pred [nos],
    output logic signed [WIDTH-1:0] innov  [noo],
    output logic                    busy,
    output logic                    done,
    output logic                    restart_cov
);

    localparam int ACC_W  = acc_width(WIDTH);
    localparam int NOS_W  = (nos > 1) ? $clog2(nos) : 1;
    localparam int NOO_W  = (noo > 1) ? $clog2(noo) : 1;
    localparam int IDX_W  = (NOS_W > NOO_W) ? NOS_W : NOO_W;

    kf_state_t               r_state;
    logic [IDX_W-1:0]        r_i;
    logic [IDX_W-1:0]        r_j;
    logic signed [WIDTH-1:0] r_y     [noo];
    logic signed [WIDTH-1:0] r_k     [nos][noo];
    logic signed [WIDTH-1:0] r_xhat  [nos];
    logic signed [WIDTH-1:0] r_xpred [nos];
    logic signed [WIDTH-1:0] r_innov [noo];
    logic                    r_k_have;
    logic                    r_busy;
    logic                    r_done;

    // Row/column indices narrowed to the size of the array they address.
    logic [NOS_W-1:0]        w_i_s;
    logic [NOO_W-1:0]        w_i_o;
    logic [NOS_W-1:0]        w_j_s;
    logic [NOO_W-1:0]        w_j_o;

    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_b;
    logic signed [WIDTH-1:0] w_r;
    logic                    w_mac_en;
    logic                    w_last_col;
    logic                    w_last_row;

    assign w_i_s = r_i[NOS_W-1:0];
    assign w_i_o = r_i[NOO_W-1:0];
    assign w_j_s = r_j[NOS_W-1:0];
    assign w_j_o = r_j[NOO_W-1:0];

    // Operand selection and matrix shape for the current MAC pass.
    always_comb begin
        w_a        = '0;
        w_b        = '0;
        w_mac_en   = 1'b0;
        w_last_col = 1'b0;
        w_last_row = 1'b0;
        case (r_state)
            ST_PRED: begin
                w_a        = Fdnk[w_i_s][w_j_s];
                w_b        = r_xhat[w_j_s];
                w_mac_en   = 1'b1;
                w_last_col = (r_j == IDX_W'(nos - 1));
                w_last_row = (r_i == IDX_W'(nos - 1));
            end
            ST_INNOV: begin
                w_a        = H[w_i_o][w_j_s];
                w_b        = r_xpred[w_j_s];
                w_mac_en   = 1'b1;
                w_last_col = (r_j == IDX_W'(nos - 1));
                w_last_row = (r_i == IDX_W'(noo - 1));
            end
            ST_UPD: begin
                w_a        = r_k[w_i_s][w_j_o];
                w_b        = r_innov[w_j_o];
                w_mac_en   = 1'b1;
                w_last_col = (r_j == IDX_W'(noo - 1));
                w_last_row = (r_i == IDX_W'(nos - 1));
            end
            default: ;
        endcase
    end

    kf_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_mac_en),
        .i_clear  (r_j == '0),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_r)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k_have <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int n = 0; n < nos; n++) begin
                r_xhat[n]  <= X0[n];
                r_xpred[n] <= '0;
                for (int m = 0; m < noo; m++) begin
                    r_k[n][m] <= '0;
                end
            end
            for (int m = 0; m < noo; m++) begin
                r_innov[m] <= '0;
                r_y[m]     <= '0;
            end
        end else begin
            // Gain is accepted only before the innovation pass consumes it.
            if (k_valid && (r_state == ST_PRED || r_state == ST_WAIT_K)) begin
                r_k      <= K;
                r_k_have <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_predict) begin
                        r_state <= ST_PRED;
                        r_busy  <= 1'b1;
                        r_y     <= y;
                        r_i     <= '0;
                        r_j     <= '0;
                    end
                end

                ST_PRED, ST_INNOV, ST_UPD: begin
                    if (w_last_col) begin
                        if (r_state == ST_PRED) begin
                            r_xpred[w_i_s] <= w_r;
                        end else if (r_state == ST_INNOV) begin
                            r_innov[w_i_o] <= r_y[w_i_o] - w_r;
                        end else begin
                            r_xhat[w_i_s] <= r_xpred[w_i_s] + w_r;
                        end
                        r_j <= '0;
                        if (w_last_row) begin
                            r_i <= '0;
                            if (r_state == ST_PRED) begin
                                r_state <= ST_WAIT_K;
                            end else if (r_state == ST_INNOV) begin
                                r_state <= ST_UPD;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_i <= r_i + IDX_W'(1);
                        end
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end

                ST_WAIT_K: begin
                    if (r_k_have || k_valid) begin
                        r_state <= ST_INNOV;
                    end
                end

                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_k_have <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x_hat       = r_xhat;
    assign x_pred      = r_xpred;
    assign innov       = r_innov;
    assign busy        = r_busy;
    assign done        = r_done;
    assign restart_cov = r_done;

endmodule : state_estimate_updater
`default_nettype wire
